// File: rtl/worker_pool_scheduler_pkg.sv
// Shared widths and FSM state encodings for the worker pool scheduler.
// The bench imports this package to see the same state names.
package worker_pool_scheduler_pkg;

    localparam int unsigned PACKET_WIDTH_DEF        = 32;
    localparam int unsigned WORKER_RESULT_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        D_EMPTY = 2'd0,
        D_PICK  = 2'd1,
        D_OFFER = 2'd2
    } disp_state_e;

    typedef enum logic {
        C_IDLE = 1'b0,
        C_HOLD = 1'b1
    } coll_state_e;

    // Successor index on a ring of n entries.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/worker_pool_scheduler_rr_pick.sv
// Combinational round-robin search: first set request at or after ptr,
// wrapping from N-1 back to 0.
module rr_pick #(
    parameter int unsigned N     = 4,
    parameter int unsigned PTR_W = 4
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic             found,
    output logic [PTR_W-1:0] index
);

    logic [2*N-1:0] rot;
    int unsigned    idx;

    always_comb begin
        found = 1'b0;
        index = '0;
        idx   = 0;
        rot   = {req, req} >> ptr;
        // Descending scan so the smallest offset from ptr wins.
        for (int unsigned i = N; i > 0; i--) begin
            if (rot[i-1]) begin
                found = 1'b1;
                idx   = 32'(ptr) + i - 1;
                if (idx >= N) begin
                    idx = idx - N;
                end
                index = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/worker_pool_scheduler.sv
// Distributes incoming packets over NUM_WORKERS workers and merges their
// results back into one stream; round-robin on both sides.
module worker_pool_scheduler
    import worker_pool_scheduler_pkg::*;
#(
    parameter int unsigned PACKET_WIDTH        = PACKET_WIDTH_DEF,
    parameter int unsigned WORKER_RESULT_WIDTH = WORKER_RESULT_WIDTH_DEF,
    parameter int unsigned NUM_WORKERS         = 4,
    parameter int unsigned PTR_W               = 4
) (
    input  logic                                       CLK,
    input  logic                                       RST,
    input  logic                                       RECEIVE_PC_VALID,
    output logic                                       RECEIVE_PC_READY,
    input  logic [PACKET_WIDTH-1:0]                    RECEIVE_PC_DATA,
    output logic [NUM_WORKERS-1:0]                     WORKER_PC_VALID,
    input  logic [NUM_WORKERS-1:0]                     WORKER_PC_READY,
    output logic [PACKET_WIDTH-1:0]                    WORKER_PC_DATA,
    input  logic [NUM_WORKERS-1:0]                     WORKER_WR_VALID,
    output logic [NUM_WORKERS-1:0]                     WORKER_WR_READY,
    input  logic [NUM_WORKERS*WORKER_RESULT_WIDTH-1:0] WORKER_WR_DATA,
    output logic                                       SEND_WR_VALID,
    input  logic                                       SEND_WR_READY,
    output logic [WORKER_RESULT_WIDTH-1:0]             SEND_WR_DATA
);

    disp_state_e                    dstate_q, dstate_d;
    coll_state_e                    cstate_q, cstate_d;
    logic [PACKET_WIDTH-1:0]        pkt_q, pkt_d;
    logic [WORKER_RESULT_WIDTH-1:0] res_q, res_d;
    logic [PTR_W-1:0]               dptr_q, dptr_d, dtgt_q, dtgt_d;
    logic [PTR_W-1:0]               cptr_q, cptr_d, cgnt_q, cgnt_d;
    logic                           recv_ready_q, recv_ready_d;

    logic                           d_found, c_found;
    logic [PTR_W-1:0]               d_idx, c_idx;
    logic [NUM_WORKERS-1:0]         dtgt_oh, cidx_oh;
    logic [WORKER_RESULT_WIDTH-1:0] res_sel;
    logic                           offer_taken;

    rr_pick #(.N(NUM_WORKERS), .PTR_W(PTR_W)) u_disp_pick (
        .req   (WORKER_PC_READY),
        .ptr   (dptr_q),
        .found (d_found),
        .index (d_idx)
    );

    rr_pick #(.N(NUM_WORKERS), .PTR_W(PTR_W)) u_coll_pick (
        .req   (WORKER_WR_VALID),
        .ptr   (cptr_q),
        .found (c_found),
        .index (c_idx)
    );

    // One-hot decode avoids indexing port vectors with a wider pointer.
    always_comb begin
        dtgt_oh = '0;
        cidx_oh = '0;
        res_sel = '0;
        for (int unsigned i = 0; i < NUM_WORKERS; i++) begin
            dtgt_oh[i] = (dtgt_q == PTR_W'(i));
            cidx_oh[i] = (c_idx == PTR_W'(i));
            if (c_idx == PTR_W'(i)) begin
                res_sel = WORKER_WR_DATA[i*WORKER_RESULT_WIDTH +: WORKER_RESULT_WIDTH];
            end
        end
        offer_taken = |(dtgt_oh & WORKER_PC_READY);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dstate_q     <= D_EMPTY;
            cstate_q     <= C_IDLE;
            pkt_q        <= '0;
            res_q        <= '0;
            dptr_q       <= '0;
            dtgt_q       <= '0;
            cptr_q       <= '0;
            cgnt_q       <= '0;
            recv_ready_q <= 1'b0;
        end else begin
            dstate_q     <= dstate_d;
            cstate_q     <= cstate_d;
            pkt_q        <= pkt_d;
            res_q        <= res_d;
            dptr_q       <= dptr_d;
            dtgt_q       <= dtgt_d;
            cptr_q       <= cptr_d;
            cgnt_q       <= cgnt_d;
            recv_ready_q <= recv_ready_d;
        end
    end

    always_comb begin
        dstate_d = dstate_q;
        pkt_d    = pkt_q;
        dptr_d   = dptr_q;
        dtgt_d   = dtgt_q;
        case (dstate_q)
            D_EMPTY: begin
                if (recv_ready_q && RECEIVE_PC_VALID) begin
                    pkt_d    = RECEIVE_PC_DATA;
                    dstate_d = D_PICK;
                end
            end
            D_PICK: begin
                if (d_found) begin
                    dtgt_d   = d_idx;
                    dstate_d = D_OFFER;
                end
            end
            D_OFFER: begin
                if (offer_taken) begin
                    dptr_d   = PTR_W'(rr_next(32'(dtgt_q), NUM_WORKERS));
                    dstate_d = D_EMPTY;
                end
            end
            default: dstate_d = D_EMPTY;
        endcase
        // Registered ready tracks the state being entered.
        recv_ready_d = (dstate_d == D_EMPTY);
    end

    always_comb begin
        cstate_d = cstate_q;
        res_d    = res_q;
        cptr_d   = cptr_q;
        cgnt_d   = cgnt_q;
        case (cstate_q)
            C_IDLE: begin
                if (c_found) begin
                    res_d    = res_sel;
                    cgnt_d   = c_idx;
                    cstate_d = C_HOLD;
                end
            end
            C_HOLD: begin
                if (SEND_WR_READY) begin
                    cptr_d   = PTR_W'(rr_next(32'(cgnt_q), NUM_WORKERS));
                    cstate_d = C_IDLE;
                end
            end
            default: cstate_d = C_IDLE;
        endcase
    end

    always_comb begin
        RECEIVE_PC_READY = recv_ready_q;
        WORKER_PC_VALID  = (dstate_q == D_OFFER) ? dtgt_oh : '0;
        WORKER_PC_DATA   = pkt_q;
        // Grant is combinational, so it must be masked while reset is held.
        WORKER_WR_READY  = (cstate_q == C_IDLE && c_found && !RST) ? cidx_oh : '0;
        SEND_WR_VALID    = (cstate_q == C_HOLD);
        SEND_WR_DATA     = res_q;
    end

endmodule

// File: tb/tb_worker_pool_scheduler.sv
// Directed bench for worker_pool_scheduler: dispatch rotation, skip/backpressure,
// collect fairness, sink stall and asynchronous reset.
module tb_worker_pool_scheduler;
    import worker_pool_scheduler_pkg::*;

    localparam int unsigned PW = 32;
    localparam int unsigned RW = 32;
    localparam int unsigned NW = 4;

    logic          clk;
    logic          rst;
    logic          rx_valid;
    logic          rx_ready;
    logic [PW-1:0] rx_data;
    logic [NW-1:0] wpc_valid;
    logic [NW-1:0] wpc_ready;
    logic [PW-1:0] wpc_data;
    logic [NW-1:0] wwr_valid;
    logic [NW-1:0] wwr_ready;
    logic [NW*RW-1:0] wwr_data;
    logic          tx_valid;
    logic          tx_ready;
    logic [RW-1:0] tx_data;

    int checks = 0;
    int errors = 0;

    worker_pool_scheduler #(
        .PACKET_WIDTH(PW),
        .WORKER_RESULT_WIDTH(RW),
        .NUM_WORKERS(NW),
        .PTR_W(4)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .RECEIVE_PC_VALID(rx_valid),
        .RECEIVE_PC_READY(rx_ready),
        .RECEIVE_PC_DATA(rx_data),
        .WORKER_PC_VALID(wpc_valid),
        .WORKER_PC_READY(wpc_ready),
        .WORKER_PC_DATA(wpc_data),
        .WORKER_WR_VALID(wwr_valid),
        .WORKER_WR_READY(wwr_ready),
        .WORKER_WR_DATA(wwr_data),
        .SEND_WR_VALID(tx_valid),
        .SEND_WR_READY(tx_ready),
        .SEND_WR_DATA(tx_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one packet for exactly the accepting edge.
    task automatic offer_pkt(input logic [PW-1:0] d);
        rx_valid = 1'b1;
        rx_data  = d;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        wwr_valid = 4'b1111;
        #1;
        checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL rst_rx_ready: got %b want 0", rx_ready); end
        checks++; if (wpc_valid !== 4'b0) begin errors++; $display("FAIL rst_wpc_valid: got %b want 0000", wpc_valid); end
        checks++; if (wpc_data !== '0) begin errors++; $display("FAIL rst_wpc_data: got %h want 0", wpc_data); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rst_tx_valid: got %b want 0", tx_valid); end
        checks++; if (tx_data !== '0) begin errors++; $display("FAIL rst_tx_data: got %h want 0", tx_data); end
        checks++; if (wwr_ready !== 4'b0) begin errors++; $display("FAIL rst_wwr_ready: got %b want 0000", wwr_ready); end
        tick();
        wwr_valid = '0;
        rst = 1'b0;
        #1;
        checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL rst_rx_ready_before_edge: got %b want 0", rx_ready); end
        tick();
        checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL rst_rx_ready_after_edge: got %b want 1", rx_ready); end
    endtask

    task automatic test_dispatch_rotation();
        logic [NW-1:0] exp_oh;
        wpc_ready = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_oh = 4'b0001 << (k % 4);
            checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL rot_rx_ready[%0d]: got %b want 1", k, rx_ready); end
            offer_pkt(32'(k));
            checks++; if (wpc_valid !== 4'b0) begin errors++; $display("FAIL rot_pick_valid[%0d]: got %b want 0000", k, wpc_valid); end
            tick();
            checks++; if (wpc_valid !== exp_oh) begin errors++; $display("FAIL rot_target[%0d]: got %b want %b", k, wpc_valid, exp_oh); end
            checks++; if (wpc_data !== 32'(k)) begin errors++; $display("FAIL rot_data[%0d]: got %h want %h", k, wpc_data, k); end
            tick();
            checks++; if (wpc_valid !== 4'b0) begin errors++; $display("FAIL rot_release[%0d]: got %b want 0000", k, wpc_valid); end
        end
    endtask

    task automatic test_skip_busy();
        // Pointer is 1 after the rotation test.
        wpc_ready = 4'b1001;
        offer_pkt(32'hAA);
        tick();
        checks++; if (wpc_valid !== 4'b1000) begin errors++; $display("FAIL skip_target: got %b want 1000", wpc_valid); end
        checks++; if (wpc_data !== 32'hAA) begin errors++; $display("FAIL skip_data: got %h want aa", wpc_data); end
        tick();
        wpc_ready = 4'b1111;
        offer_pkt(32'hAB);
        tick();
        checks++; if (wpc_valid !== 4'b0001) begin errors++; $display("FAIL skip_ptr_wrap: got %b want 0001", wpc_valid); end
        tick();
    endtask

    task automatic test_backpressure();
        // Pointer is 1 here.
        wpc_ready = 4'b0000;
        offer_pkt(32'hBB);
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++; if (rx_ready !== 1'b0 || wpc_valid !== 4'b0) begin
                errors++; $display("FAIL bp_hold[%0d]: got ready=%b valid=%b want 0 0000", k, rx_ready, wpc_valid);
            end
        end
        wpc_ready = 4'b0100;
        #1;
        checks++; if (wpc_valid !== 4'b0) begin errors++; $display("FAIL bp_no_early_offer: got %b want 0000", wpc_valid); end
        tick();
        checks++; if (wpc_valid !== 4'b0100) begin errors++; $display("FAIL bp_target: got %b want 0100", wpc_valid); end
        checks++; if (wpc_data !== 32'hBB) begin errors++; $display("FAIL bp_data: got %h want bb", wpc_data); end
        // Worker 3 becoming ready must not retarget the held offer.
        wpc_ready = 4'b1000;
        tick();
        checks++; if (wpc_valid !== 4'b0100) begin errors++; $display("FAIL bp_no_retarget: got %b want 0100", wpc_valid); end
        wpc_ready = 4'b0100;
        tick();
        checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL bp_recover: got %b want 1", rx_ready); end
        wpc_ready = 4'b0000;
    endtask

    task automatic test_collect_fairness();
        tx_ready = 1'b1;
        wwr_data = '0;
        wwr_data[0*RW +: RW] = 32'h1111;
        wwr_data[2*RW +: RW] = 32'h2222;
        wwr_valid = 4'b0101;
        #1;
        checks++; if (wwr_ready !== 4'b0001) begin errors++; $display("FAIL cf_grant0: got %b want 0001", wwr_ready); end
        tick();
        wwr_valid = 4'b0100;
        #1;
        checks++; if (tx_valid !== 1'b1 || tx_data !== 32'h1111) begin errors++; $display("FAIL cf_out0: got v=%b d=%h want 1 1111", tx_valid, tx_data); end
        checks++; if (wwr_ready !== 4'b0) begin errors++; $display("FAIL cf_hold0_ready: got %b want 0000", wwr_ready); end
        tick();
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL cf_idle0: got %b want 0", tx_valid); end
        checks++; if (wwr_ready !== 4'b0100) begin errors++; $display("FAIL cf_grant2: got %b want 0100", wwr_ready); end
        tick();
        wwr_valid = 4'b0000;
        #1;
        checks++; if (tx_valid !== 1'b1 || tx_data !== 32'h2222) begin errors++; $display("FAIL cf_out1: got v=%b d=%h want 1 2222", tx_valid, tx_data); end
        checks++; if (wwr_ready !== 4'b0) begin errors++; $display("FAIL cf_hold1_ready: got %b want 0000", wwr_ready); end
        tick();
        checks++; if (tx_valid !== 1'b0 || wwr_ready !== 4'b0) begin errors++; $display("FAIL cf_drain: got v=%b r=%b want 0 0000", tx_valid, wwr_ready); end
    endtask

    task automatic test_multi_result();
        // Pointer is 3: worker 0 wins first, worker 1 must precede worker 0's second result.
        wwr_data = '0;
        wwr_data[0*RW +: RW] = 32'hA0A0;
        wwr_data[1*RW +: RW] = 32'hC1C1;
        wwr_valid = 4'b0011;
        #1;
        checks++; if (wwr_ready !== 4'b0001) begin errors++; $display("FAIL mr_grant_a: got %b want 0001", wwr_ready); end
        tick();
        wwr_data[0*RW +: RW] = 32'hB0B0;
        #1;
        checks++; if (tx_data !== 32'hA0A0) begin errors++; $display("FAIL mr_out_a: got %h want a0a0", tx_data); end
        tick();
        checks++; if (wwr_ready !== 4'b0010) begin errors++; $display("FAIL mr_grant_c: got %b want 0010", wwr_ready); end
        tick();
        wwr_valid = 4'b0001;
        #1;
        checks++; if (tx_data !== 32'hC1C1) begin errors++; $display("FAIL mr_out_c: got %h want c1c1", tx_data); end
        tick();
        checks++; if (wwr_ready !== 4'b0001) begin errors++; $display("FAIL mr_grant_b: got %b want 0001", wwr_ready); end
        tick();
        wwr_valid = 4'b0000;
        #1;
        checks++; if (tx_data !== 32'hB0B0) begin errors++; $display("FAIL mr_out_b: got %h want b0b0", tx_data); end
        tick();
    endtask

    task automatic test_sink_stall_reset();
        // Pointer is 1: worker 1 is granted before worker 2.
        tx_ready = 1'b0;
        wwr_data = '0;
        wwr_data[1*RW +: RW] = 32'h4444;
        wwr_data[2*RW +: RW] = 32'h3333;
        wwr_valid = 4'b0110;
        #1;
        checks++; if (wwr_ready !== 4'b0010) begin errors++; $display("FAIL ss_grant: got %b want 0010", wwr_ready); end
        tick();
        wwr_valid = 4'b0100;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++; if (tx_valid !== 1'b1 || tx_data !== 32'h4444 || wwr_ready !== 4'b0) begin
                errors++; $display("FAIL ss_stall[%0d]: got v=%b d=%h r=%b want 1 4444 0000", k, tx_valid, tx_data, wwr_ready);
            end
            tick();
        end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL ss_async_valid: got %b want 0", tx_valid); end
        checks++; if (tx_data !== '0) begin errors++; $display("FAIL ss_async_data: got %h want 0", tx_data); end
        checks++; if (wwr_ready !== 4'b0) begin errors++; $display("FAIL ss_async_ready: got %b want 0000", wwr_ready); end
        checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL ss_async_rx_ready: got %b want 0", rx_ready); end
        tick();
        wwr_valid = 4'b0000;
        rst = 1'b0;
        tx_ready = 1'b1;
        tick();
        checks++; if (rx_ready !== 1'b1 || tx_valid !== 1'b0) begin errors++; $display("FAIL ss_post_reset: got rdy=%b v=%b want 1 0", rx_ready, tx_valid); end
        // Dispatch pointer must be back at 0.
        wpc_ready = 4'b1111;
        offer_pkt(32'hCC);
        tick();
        checks++; if (wpc_valid !== 4'b0001) begin errors++; $display("FAIL ss_dptr_reset: got %b want 0001", wpc_valid); end
        tick();
    endtask

    initial begin
        rst       = 1'b1;
        rx_valid  = 1'b0;
        rx_data   = '0;
        wpc_ready = '0;
        wwr_valid = '0;
        wwr_data  = '0;
        tx_ready  = 1'b0;
        test_reset();
        test_dispatch_rotation();
        test_skip_busy();
        test_backpressure();
        test_collect_fairness();
        test_multi_result();
        test_sink_stall_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
